// File: rtl/fifo_ram_outq.sv
// rtl/fifo_ram_outq.sv - two-entry output shift queue fed by RAM read data
module fifo_ram_outq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cap,
   input  logic [WIDTH-1:0] cap_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       q_cnt
);

   logic [WIDTH-1:0] q0, q1, q0_n, q1_n;
   logic [1:0]       cnt_n, idx;
   logic             pop_eff;

   always_comb begin
      pop_eff = pop & (q_cnt != 2'd0);
      q0_n    = q0;
      q1_n    = q1;
      if (pop_eff) q0_n = q1;
      // capture slot accounts for a pop in the same cycle
      idx = q_cnt - {1'b0, pop_eff};
      if (cap) begin
         if (idx == 2'd0) q0_n = cap_data;
         else             q1_n = cap_data;
      end
      cnt_n = q_cnt + {1'b0, cap} - {1'b0, pop_eff};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) q_cnt <= 2'd0;
      else        q_cnt <= cnt_n;
   end

   always_ff @(posedge clk) begin
      q0 <= q0_n;
      q1 <= q1_n;
   end

   assign head = q0;

endmodule

// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - stream FIFO controller driving an external 1-cycle dual-port RAM
module fifo_ram_ctrl #(
   parameter  int WIDTH  = 8,
   parameter  int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int LVL_W  = $clog2(DEPTH + 3)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [LVL_W-1:0]  level,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [WIDTH-1:0]  ram_din,
   output logic              ram_rd,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [WIDTH-1:0]  ram_dout
);

   localparam int                CNT_W     = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] wptr, rptr;
   logic [CNT_W-1:0]  ram_cnt;
   logic              rd_pend, prio;
   logic [1:0]        q_cnt;
   logic              not_full, rd_want, wr_want, rd_gnt, push, pop;

   always_comb begin
      not_full = (ram_cnt != FULL_CNT);
      // depends on registered state only, so out_ready never reaches the RAM port
      rd_want  = (ram_cnt != '0) && ((q_cnt + {1'b0, rd_pend}) < 2'd2);
      wr_want  = in_valid & not_full;
      in_ready = rst_n & not_full & ~(rd_want & prio);
      push     = in_valid & in_ready;
      rd_gnt   = rst_n & rd_want & ~(wr_want & ~prio);
      out_valid = rst_n & (q_cnt != 2'd0);
      pop      = out_valid & out_ready;
      level    = rst_n ? (LVL_W'(ram_cnt) + LVL_W'(q_cnt) + LVL_W'(rd_pend)) : '0;
   end

   assign ram_wr    = push;
   assign ram_waddr = wptr;
   assign ram_din   = in_data;
   assign ram_rd    = rd_gnt;
   assign ram_raddr = rptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         ram_cnt <= '0;
         rd_pend <= 1'b0;
         prio    <= 1'b0;
      end else begin
         if (push)   wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
         if (rd_gnt) rptr <= (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
         ram_cnt <= ram_cnt + CNT_W'(push) - CNT_W'(rd_gnt);
         rd_pend <= rd_gnt;
         // alternate winners whenever both sides compete
         if (wr_want & rd_want) prio <= ~prio;
      end
   end

   fifo_ram_outq #(.WIDTH(WIDTH)) u_outq (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap      (rd_pend),
      .cap_data (ram_dout),
      .pop      (pop),
      .head     (out_data),
      .q_cnt    (q_cnt)
   );

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// tb/tb_fifo_ram_ctrl.sv - directed bench for fifo_ram_ctrl with DEPTH=4 and DEPTH=5 instances
module tb_fifo_ram_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   logic       iv_a, ir_a, ov_a, or_a, wr_a, rd_a;
   logic [7:0] id_a, od_a, din_a, dout_a;
   logic [2:0] lvl_a;
   logic [1:0] wa_a, ra_a;
   logic [7:0] mem_a [0:3];

   logic       iv_b, ir_b, ov_b, or_b, wr_b, rd_b;
   logic [7:0] id_b, od_b, din_b, dout_b;
   logic [2:0] lvl_b;
   logic [2:0] wa_b, ra_b;
   logic [7:0] mem_b [0:4];

   fifo_ram_ctrl #(.WIDTH(8), .DEPTH(4)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
      .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .level(lvl_a),
      .ram_wr(wr_a), .ram_waddr(wa_a), .ram_din(din_a), .ram_rd(rd_a),
      .ram_raddr(ra_a), .ram_dout(dout_a)
   );

   fifo_ram_ctrl #(.WIDTH(8), .DEPTH(5)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
      .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .level(lvl_b),
      .ram_wr(wr_b), .ram_waddr(wa_b), .ram_din(din_b), .ram_rd(rd_b),
      .ram_raddr(ra_b), .ram_dout(dout_b)
   );

   always @(posedge clk) begin
      if (wr_a) mem_a[wa_a] <= din_a;
      if (rd_a) dout_a <= mem_a[ra_a];
      if (wr_b && wa_b < 3'd5) mem_b[wa_b] <= din_b;
      if (rd_b) dout_b <= (ra_b < 3'd5) ? mem_b[ra_b] : 8'hxx;
   end

   logic saw_w4 = 1'b0, saw_r4 = 1'b0, addr_bad = 1'b0;
   always @(posedge clk) begin
      if (wr_b && wa_b == 3'd4) saw_w4 <= 1'b1;
      if (rd_b && ra_b == 3'd4) saw_r4 <= 1'b1;
      if ((wr_b && wa_b > 3'd4) || (rd_b && ra_b > 3'd4)) addr_bad <= 1'b1;
   end

   logic [7:0] sb [$];
   int n_wr, n_rd, n_both;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step_b(input logic v, input logic [7:0] d, input logic r);
      iv_b = v; id_b = d; or_b = r;
      #2;
      if (wr_b) n_wr++;
      if (rd_b) n_rd++;
      if (wr_b && rd_b) n_both++;
      if (v && ir_b) sb.push_back(d);
      if (r && ov_b) begin
         if (sb.size() == 0) chk("pop_unexpected", sb.size(), 1);
         else                chk("pop_data", od_b, sb.pop_front());
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int pushed, got;
      logic found;
      rst_n = 1'b0;
      iv_a = 1'b1; id_a = 8'h00; or_a = 1'b0;
      iv_b = 1'b1; id_b = 8'h00; or_b = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready_b", ir_b, 0);
      chk("rst_ram_wr_b", wr_b, 0);
      chk("rst_level_a", lvl_a, 0);
      rst_n = 1'b1; iv_a = 1'b0; iv_b = 1'b0;
      #1;
      chk("idle_level_b", lvl_b, 0);
      chk("idle_out_valid_b", ov_b, 0);
      chk("idle_in_ready_b", ir_b, 1);
      chk("idle_ram_rd_b", rd_b, 0);

      // single push latency
      iv_b = 1'b1; id_b = 8'hA5; or_b = 1'b1;
      #1;
      chk("t0_ram_wr", wr_b, 1);
      chk("t0_waddr", wa_b, 0);
      @(posedge clk); #1; iv_b = 1'b0; #1;
      chk("t1_level", lvl_b, 1);
      chk("t1_out_valid", ov_b, 0);
      chk("t1_ram_rd", rd_b, 1);
      @(posedge clk); #2;
      chk("t2_out_valid", ov_b, 0);
      chk("t2_level", lvl_b, 1);
      @(posedge clk); #2;
      chk("t3_out_valid", ov_b, 1);
      chk("t3_out_data", od_b, 8'hA5);
      chk("t3_level", lvl_b, 1);
      @(posedge clk); #2;
      chk("t4_level", lvl_b, 0);
      chk("t4_out_valid", ov_b, 0);
      or_b = 1'b0;

      // DEPTH=4 fill to capacity, blocked push, ordered drain, empty pop
      pushed = 0;
      for (int i = 0; i < 40 && pushed < 6; i++) begin
         iv_a = 1'b1; id_a = 8'(pushed + 1);
         #1;
         if (ir_a) pushed++;
         @(posedge clk); #1;
      end
      chk("full_pushed", pushed, 6);
      iv_a = 1'b1; id_a = 8'h77;
      #1;
      chk("full_in_ready", ir_a, 0);
      chk("full_level", lvl_a, 6);
      chk("full_ram_wr", wr_a, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("full_level_hold", lvl_a, 6);
      chk("full_ram_kept", mem_a[0], 8'h05);
      iv_a = 1'b0; or_a = 1'b1;
      got = 0;
      for (int i = 0; i < 40 && got < 6; i++) begin
         #1;
         if (ov_a) begin
            chk("drain_data", od_a, got + 1);
            got++;
         end
         @(posedge clk); #1;
      end
      chk("drain_count", got, 6);
      #1;
      chk("empty_level", lvl_a, 0);
      chk("empty_out_valid", ov_a, 0);
      @(posedge clk); #2;
      chk("empty_pop_level", lvl_a, 0);
      chk("empty_pop_ram_rd", rd_a, 0);
      or_a = 1'b0;

      // contention with the queue pre-filled
      for (int i = 0; i < 20 && lvl_b < 3'd4; i++) step_b(1'b1, 8'(8'h10 + i), 1'b0);
      repeat (3) step_b(1'b0, 8'h00, 1'b0);
      n_wr = 0; n_rd = 0; n_both = 0;
      for (int i = 0; i < 20; i++) step_b(1'b1, 8'(8'h40 + i), 1'b1);
      chk("contend_both_strobes", n_both, 0);
      chk("contend_wr_progress", n_wr >= 8, 1);
      chk("contend_rd_progress", n_rd >= 8, 1);
      for (int i = 0; i < 60 && sb.size() != 0; i++) step_b(1'b0, 8'h00, 1'b1);
      chk("contend_drained", sb.size(), 0);

      // reset while a read is in flight
      for (int i = 0; i < 30 && lvl_b < 3'd5; i++) step_b(1'b1, 8'(8'h80 + i), 1'b0);
      repeat (3) step_b(1'b0, 8'h00, 1'b0);
      chk("pre_rst_level", lvl_b, 5);
      step_b(1'b1, 8'h66, 1'b1);
      iv_b = 1'b0; or_b = 1'b0;
      #1;
      chk("pre_rst_ram_rd", rd_b, 1);
      @(posedge clk); #1;
      chk("pend_level", lvl_b, 5);
      rst_n = 1'b0;
      #1;
      chk("in_rst_out_valid", ov_b, 0);
      chk("in_rst_in_ready", ir_b, 0);
      chk("in_rst_level", lvl_b, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_level", lvl_b, 0);
      chk("post_rst_out_valid", ov_b, 0);
      chk("post_rst_in_ready", ir_b, 1);
      sb.delete();
      step_b(1'b1, 8'h3C, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (ov_b) found = 1'b1;
         else step_b(1'b0, 8'h00, 1'b0);
      end
      chk("post_rst_valid", found, 1);
      chk("post_rst_head", od_b, 8'h3C);
      step_b(1'b0, 8'h00, 1'b1);

      // random traffic across pointer wrap
      for (int i = 0; i < 200; i++)
         step_b(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 60 && sb.size() != 0; i++) step_b(1'b0, 8'h00, 1'b1);
      chk("rand_drained", sb.size(), 0);
      chk("rand_level", lvl_b, 0);
      chk("rand_wrap_w4", saw_w4, 1);
      chk("rand_wrap_r4", saw_r4, 1);
      chk("rand_addr_range", addr_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
